// File: rtl/tau_accumulator.sv
// ============================================================================
// tau_accumulator
// ----------------------------------------------------------------------------
// Downstream stage of the temporal-unary MAC. While a unary operand streams
// out, the encoder emits one shifted partial product per cycle. This block
// sums those partial products across all elements of a dot product. It then
// offers the finished sum to the output buffer over a valid/ready handshake.
//
// Elements are delimited by elem_done, the encoder's done pulse. vec_last is
// qualified by elem_done and marks the final element of the vector.
//
// Optional feature (compile-time macro TAU_ACC_SAT_EN):
//   defined   : an add past 2^ACC_BITS-1 clamps the accumulator at all-ones.
//   undefined : modulo-2^ACC_BITS wrap.
//   In both builds the add sets the sticky overflow flag.
//
// Ports:
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   start      in   begin a new dot product (clears accumulator and flags)
//   pp_valid   in   pp carries a valid partial product this cycle
//   pp         in   [PP_BITS-1:0] unsigned shifted partial product
//   elem_done  in   current element's unary stream has ended
//   vec_last   in   with elem_done: this was the final element
//   acc_out    out  [ACC_BITS-1:0] registered accumulator / result
//   acc_valid  out  acc_out holds a finished result (HOLD state)
//   acc_ready  in   downstream accepts the result
//   busy       out  accumulating (ACCUM state)
//   overflow   out  sticky per dot product: the sum exceeded ACC_BITS
//   len_err    out  sticky per dot product: VEC_LEN_MAX elements arrived
//                   without vec_last
// ============================================================================
module tau_accumulator #(
    parameter int BITWIDTH    = 8,
    parameter int PP_BITS     = 2 * BITWIDTH,
    parameter int VEC_LEN_MAX = 16,
    parameter int ACC_BITS    = PP_BITS + $clog2(VEC_LEN_MAX)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                pp_valid,
    input  logic [PP_BITS-1:0]  pp,
    input  logic                elem_done,
    input  logic                vec_last,
    output logic [ACC_BITS-1:0] acc_out,
    output logic                acc_valid,
    input  logic                acc_ready,
    output logic                busy,
    output logic                overflow,
    output logic                len_err
);

    // The counter must be able to represent VEC_LEN_MAX itself.
    localparam int CNT_W = $clog2(VEC_LEN_MAX + 1);
    // The sum is one bit wider than the wider operand, so a carry past
    // ACC_BITS is always visible, even if ACC_BITS is overridden below PP_BITS.
    localparam int SUM_W = ((ACC_BITS > PP_BITS) ? ACC_BITS : PP_BITS) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [ACC_BITS-1:0] acc;
    logic [CNT_W-1:0]    elem_count;
    logic                ovf_q;
    logic                len_q;

    // ------------------------------------------------------------------
    // Adder: zero-extend both operands, then detect carry past ACC_BITS.
    // ------------------------------------------------------------------
    logic [SUM_W-1:0]    sum_full;
    logic                carry;
    logic [ACC_BITS-1:0] acc_add;

    assign sum_full = SUM_W'(acc) + SUM_W'(pp);
    assign carry    = |sum_full[SUM_W-1:ACC_BITS];

`ifdef TAU_ACC_SAT_EN
    // Once the accumulator sits at all-ones, any non-zero add carries again.
    // The value therefore stays pinned at the clamp.
    assign acc_add = carry ? {ACC_BITS{1'b1}} : sum_full[ACC_BITS-1:0];
`else
    assign acc_add = sum_full[ACC_BITS-1:0];
`endif

    // This elem_done would be the VEC_LEN_MAX-th element.
    logic cnt_hit;
    logic elem_end;

    assign cnt_hit  = (elem_count == CNT_W'(VEC_LEN_MAX - 1));
    assign elem_end = elem_done && (vec_last || cnt_hit);

    // A start clears the datapath in three cases:
    //   - from IDLE;
    //   - as a restart in ACCUM;
    //   - together with the result handshake in HOLD, with no idle bubble.
    // In HOLD without acc_ready the start is dropped, which protects the
    // pending result.
    logic clear;

    always_comb begin
        clear = 1'b0;
        unique case (state)
            S_IDLE:  clear = start;
            S_ACCUM: clear = start;
            S_HOLD:  clear = start && acc_ready;
            default: clear = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                // A restart takes priority over ending the element.
                if (start)         state_nxt = S_ACCUM;
                else if (elem_end) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (acc_ready) state_nxt = start ? S_ACCUM : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        acc_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            S_ACCUM: busy      = 1'b1;
            S_HOLD:  acc_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: accumulator, element counter and sticky flags.
    // Updates happen only in ACCUM, so HOLD keeps everything stable.
    // A pp that arrives with the final elem_done is still added.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            elem_count <= '0;
            ovf_q      <= 1'b0;
            len_q      <= 1'b0;
        end else if (clear) begin
            // A pp in the restart cycle is discarded.
            acc        <= '0;
            elem_count <= '0;
            ovf_q      <= 1'b0;
            len_q      <= 1'b0;
        end else if (state == S_ACCUM) begin
            if (pp_valid) begin
                acc <= acc_add;
                if (carry) ovf_q <= 1'b1;
            end
            if (elem_done) begin
                elem_count <= elem_count + CNT_W'(1);
                if (cnt_hit && !vec_last) len_q <= 1'b1;
            end
        end
    end

    assign acc_out  = acc;
    assign overflow = ovf_q;
    assign len_err  = len_q;

endmodule

// File: tb/tb_tau_accumulator.sv
// ============================================================================
// tb_tau_accumulator
// ----------------------------------------------------------------------------
// Two instances share one stimulus stream:
//   - dut_a: default parameters (ACC_BITS = 20).
//   - dut_b: ACC_BITS = 16, which exercises the overflow path.
// The reference model keeps the mathematical (unbounded) sum and the number
// of elements seen. Expected outputs come from plain arithmetic on those
// values: modulo or clamp at 2^W-1, a threshold test for overflow, and a
// count test for len_err.
// ============================================================================
module tb_tau_accumulator;

    localparam int AW_A = 20;
    localparam int AW_B = 16;
    localparam int VMAX = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start, pp_valid, elem_done, vec_last, acc_ready;
    logic [15:0]     pp;

    logic [AW_A-1:0] acc_a;
    logic            valid_a, busy_a, ovf_a, len_a;
    logic [AW_B-1:0] acc_b;
    logic            valid_b, busy_b, ovf_b, len_b;

    always #5 clk = ~clk;

    tau_accumulator dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .pp_valid(pp_valid),
        .pp(pp), .elem_done(elem_done), .vec_last(vec_last),
        .acc_out(acc_a), .acc_valid(valid_a), .acc_ready(acc_ready),
        .busy(busy_a), .overflow(ovf_a), .len_err(len_a)
    );

    tau_accumulator #(.ACC_BITS(AW_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .pp_valid(pp_valid),
        .pp(pp), .elem_done(elem_done), .vec_last(vec_last),
        .acc_out(acc_b), .acc_valid(valid_b), .acc_ready(acc_ready),
        .busy(busy_b), .overflow(ovf_b), .len_err(len_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    longint m_sum;
    int     m_cnt;
    bit     m_last;
    bit     in_accum;
    longint e_acc_a, e_acc_b;
    bit     e_ovf_a, e_ovf_b, e_len;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic longint exp_acc(input longint s, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
`ifdef TAU_ACC_SAT_EN
        return (s > mx) ? mx : s;
`else
        return s & mx;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start = 1'b0; pp_valid = 1'b0; elem_done = 1'b0; vec_last = 1'b0;
        acc_ready = 1'b0; pp = 16'($urandom);
    endtask

    task automatic m_clear();
        m_sum = 0; m_cnt = 0; m_last = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_acc_a"}, 32'(acc_a), 32'd0);
        chk({tag, "_acc_b"}, 32'(acc_b), 32'd0);
        chk({tag, "_flags"}, {28'd0, valid_a, busy_a, ovf_a, len_a}, 32'd0);
        chk({tag, "_flags_b"}, {28'd0, valid_b, busy_b, ovf_b, len_b}, 32'd0);
    endtask

    // Start from IDLE. Garbage on pp/acc_ready in the same cycle must be ignored.
    task automatic begin_vec();
        idle_in();
        start = 1'b1; pp_valid = 1'b1; pp = 16'($urandom);
        acc_ready = 1'($urandom);
        step();
        idle_in();
        chk("start_busy", 32'(busy_a & busy_b), 32'd1);
        chk("start_acc", 32'(acc_a) | 32'(acc_b), 32'd0);
        m_clear();
        in_accum = 1'b1;
    endtask

    // One ACCUM cycle. The model adds pp and counts elements.
    task automatic cyc(input bit v, input logic [15:0] p, input bit d, input bit l);
        start = 1'b0; pp_valid = v; pp = p; elem_done = d; vec_last = l;
        acc_ready = 1'($urandom);
        if (v) m_sum += longint'(p);
        if (d) begin
            m_cnt++;
            if (l) m_last = 1'b1;
        end
        step();
        idle_in();
    endtask

    // One element: npp partial products with random gaps.
    // elem_done rides on the final pp.
    task automatic elem(input int npp, input bit last);
        if (npp == 0) cyc(1'b0, 16'($urandom), 1'b1, last);
        for (int i = 0; i < npp; i++) begin
            if ($urandom_range(0, 2) == 0) cyc(1'b0, 16'($urandom), 1'b0, 1'b0);
            cyc(1'b1, 16'($urandom), i == npp - 1, last && (i == npp - 1));
        end
    endtask

    // Checked one cycle after the final elem_done.
    task automatic check_result(input string tag);
        e_acc_a = exp_acc(m_sum, AW_A);
        e_acc_b = exp_acc(m_sum, AW_B);
        e_ovf_a = (m_sum > ((longint'(1) << AW_A) - 1));
        e_ovf_b = (m_sum > ((longint'(1) << AW_B) - 1));
        e_len   = (m_cnt == VMAX) && !m_last;
        chk({tag, "_valid"}, {30'd0, valid_a, valid_b}, 32'd3);
        chk({tag, "_busy"}, {30'd0, busy_a, busy_b}, 32'd0);
        chk({tag, "_acc_a"}, 32'(acc_a), 32'(e_acc_a));
        chk({tag, "_acc_b"}, 32'(acc_b), 32'(e_acc_b));
        chk({tag, "_ovf"}, {30'd0, ovf_a, ovf_b}, {30'd0, e_ovf_a, e_ovf_b});
        chk({tag, "_len"}, {30'd0, len_a, len_b}, {30'd0, e_len, e_len});
        in_accum = 1'b0;
    endtask

    // Backpressure for wait_cyc cycles, with hostile inputs driven throughout.
    // Then the handshake, optionally with a same-cycle start.
    task automatic hold_and_release(input int wait_cyc, input bit st);
        for (int k = 0; k < wait_cyc; k++) begin
            start = 1'($urandom); pp_valid = 1'b1; pp = 16'($urandom);
            elem_done = 1'($urandom); vec_last = 1'($urandom); acc_ready = 1'b0;
            step();
            chk("hold_acc_a", 32'(acc_a), 32'(e_acc_a));
            chk("hold_st", {28'd0, valid_a, busy_a, ovf_b, len_a},
                {28'd0, 1'b1, 1'b0, e_ovf_b, e_len});
        end
        idle_in();
        acc_ready = 1'b1; start = st; pp_valid = 1'b1; pp = 16'hFFFF;
        step();
        idle_in();
        if (st) begin
            chk("hs_start", {29'd0, busy_a, valid_a, ovf_a}, 32'd4);
            chk("hs_start_acc", 32'(acc_a) | 32'(acc_b), 32'd0);
            m_clear();
            in_accum = 1'b1;
        end else begin
            chk("hs_idle", {28'd0, busy_a, valid_a, busy_b, valid_b}, 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        in_accum = 1'b0;
        m_clear();
        idle_in();
        #2;
        chk_all_zero("reset");
        step(); step();
        reset_n = 1'b1;
        step();

        // IDLE ignores pp_valid, elem_done and acc_ready.
        pp_valid = 1'b1; pp = 16'h1234; elem_done = 1'b1; vec_last = 1'b1; acc_ready = 1'b1;
        step();
        idle_in();
        chk_all_zero("idle_ign");

        // 1: single element
        begin_vec();
        cyc(1'b1, 16'h0010, 1'b0, 1'b0);
        cyc(1'b1, 16'h0040, 1'b1, 1'b1);
        check_result("t1");
        chk("t1_val", 32'(acc_a), 32'h50);
        hold_and_release(0, 1'b0);

        // 2: three elements; 3: backpressure followed by handshake with start
        begin_vec();
        cyc(1'b1, 16'h0100, 1'b1, 1'b0);
        cyc(1'b1, 16'h0020, 1'b0, 1'b0);
        cyc(1'b1, 16'h0003, 1'b1, 1'b0);
        cyc(1'b1, 16'h00FF, 1'b1, 1'b1);
        check_result("t2");
        chk("t2_val", 32'(acc_a), 32'h222);
        hold_and_release(5, 1'b1);

        // 4: overflow in the 16-bit instance (already in ACCUM)
        cyc(1'b1, 16'hFFFF, 1'b0, 1'b0);
        cyc(1'b1, 16'hFFFF, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1);
        check_result("t4");
`ifdef TAU_ACC_SAT_EN
        chk("t4_b", 32'(acc_b), 32'hFFFF);
`else
        chk("t4_b", 32'(acc_b), 32'hFFFE);
`endif
        chk("t4_ovf_b", 32'(ovf_b), 32'd1);
        hold_and_release(1, 1'b0);

        // 5: length error
        begin_vec();
        for (int i = 0; i < VMAX; i++) cyc(1'b1, 16'h0001, 1'b1, 1'b0);
        check_result("t5");
        chk("t5_len", {31'd0, len_a}, 32'd1);
        hold_and_release(2, 1'b0);

        // 6a: asynchronous reset mid-ACCUM, checked between clock edges
        begin_vec();
        cyc(1'b1, 16'h0100, 1'b0, 1'b0);
        cyc(1'b1, 16'h0023, 1'b0, 1'b0);
        chk("t6_pre", 32'(acc_a), 32'h123);
        reset_n = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        step();
        reset_n = 1'b1;
        in_accum = 1'b0;
        step();
        chk_all_zero("t6_post");

        // 6b: restart drops the pp that arrives in the same cycle
        begin_vec();
        cyc(1'b1, 16'h0030, 1'b0, 1'b0);
        start = 1'b1; pp_valid = 1'b1; pp = 16'h0044;
        step();
        idle_in();
        m_clear();
        chk("t6_restart", {31'd0, busy_a}, 32'd1);
        chk("t6_restart_acc", 32'(acc_a), 32'd0);
        cyc(1'b1, 16'h0005, 1'b1, 1'b1);
        check_result("t6b");
        hold_and_release(0, 1'b0);

        // Randomized vectors
        for (int v = 0; v < 40; v++) begin
            int  n;
            bit  lst;
            n   = $urandom_range(1, VMAX);
            lst = (n < VMAX) ? 1'b1 : 1'($urandom);
            if (!in_accum) begin_vec();
            for (int e = 0; e < n; e++) elem($urandom_range(0, 4), lst && (e == n - 1));
            check_result("rnd");
            hold_and_release($urandom_range(0, 3), 1'($urandom));
        end
        if (in_accum) begin
            elem(1, 1'b1);
            check_result("rnd_end");
            hold_and_release(0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tau_accumulator.md
Name: tau_accumulator

Overview:
Downstream stage of the temporal-unary MAC. Consumes the shifted partial products emitted one per cycle while each unary operand streams out, and accumulates them across the elements of a dot product. Presents the finished sum with a valid/ready handshake to the output buffer.
Each accepted element is one operand pair; its stream ends with the encoder's done pulse.

Parameters:
BITWIDTH, 8, operand width of the MAC.
PP_BITS, 2*BITWIDTH, width of each partial product.
VEC_LEN_MAX, 16, maximum elements per dot product; must be at least 2.
ACC_BITS, PP_BITS+$clog2(VEC_LEN_MAX), accumulator and result width; overridable.

Ports:
clk  in  1  clock.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  begin a new dot product; clears the accumulator.
pp_valid  in  1  pp is a valid partial product this cycle.
pp  in  PP_BITS  shifted partial product, unsigned.
elem_done  in  1  the current element's unary stream has ended (encoder done).
vec_last  in  1  qualified by elem_done; marks the final element.
acc_out  out  ACC_BITS  accumulated result, registered.
acc_valid  out  1  acc_out holds a finished result.
acc_ready  in  1  downstream accepts the result.
busy  out  1  high in the ACCUM state.
overflow  out  1  sticky per dot product; the sum exceeded ACC_BITS.
len_err  out  1  sticky per dot product; VEC_LEN_MAX elements were reached without vec_last.

Behaviour:
- Reset (asynchronous): every output goes to 0 (acc_out, acc_valid, busy, overflow, len_err); elem_count goes to 0; state goes to IDLE.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - pp_valid, elem_done and acc_ready are ignored.
  - start -> ACCUM. acc, elem_count, overflow and len_err are cleared.
- ACCUM (busy=1):
  - pp_valid -> acc <= acc + pp, with pp zero-extended.
  - Carry out of ACC_BITS -> acc wraps and overflow is set.
  - elem_done -> elem_count increments.
  - elem_done with vec_last -> HOLD.
  - elem_done that makes elem_count reach VEC_LEN_MAX -> len_err=1, go to HOLD.
  - A pp_valid in the same cycle as the final elem_done is included in the result.
  - start in ACCUM -> restart. acc, count and flags clear, state stays ACCUM, and any pp in that cycle is discarded.
- HOLD:
  - acc_valid=1. acc_out, overflow and len_err are held stable until acc_ready.
  - On acc_valid && acc_ready -> IDLE, and acc_valid drops next cycle.
  - start in the same cycle as the handshake -> ACCUM with a cleared accumulator; no bubble.
  - start without acc_ready -> ignored; the result is never dropped.
  - pp_valid and elem_done -> ignored.
- Latency: final elem_done at cycle N -> acc_valid=1 and the complete sum on acc_out at cycle N+1.
- acc_out shows the running sum during ACCUM; it is only meaningful while acc_valid=1.
- Reset mid-operation: everything is discarded, state returns to IDLE, outputs read 0.

Optional Feature:
TAU_ACC_SAT_EN
- Defined: an add that would exceed 2^ACC_BITS-1 clamps acc to 2^ACC_BITS-1 and sets overflow. Later adds keep the value at the clamp.
- Undefined: modulo-2^ACC_BITS wrap with sticky overflow, as described in Behaviour.

Test Plan:
1. Single element, default params.
   - Stimulus: start; pp=0x0010 then pp=0x0040 on consecutive cycles; elem_done+vec_last with the second pp.
   - Response: next cycle acc_valid=1, acc_out=0x00050, overflow=0, len_err=0. IDLE after acc_ready.
2. Three elements.
   - Stimulus: element sums 0x0100, 0x0023 and 0x00FF, each ended by elem_done; vec_last on the third.
   - Response: acc_out=0x00222, acc_valid exactly one cycle after the last elem_done.
3. Backpressure.
   - Stimulus: hold acc_ready=0 for 5 cycles while driving pp_valid pp=0xFFFF and start.
   - Response: acc_out stays 0x00222 and acc_valid stays 1. On acc_ready+start in the same cycle, the next cycle has busy=1 and acc_out=0.
4. Overflow, ACC_BITS=16.
   - Stimulus: pp=0xFFFF twice, then elem_done+vec_last.
   - Response: acc_out=0xFFFE, overflow=1. With TAU_ACC_SAT_EN: acc_out=0xFFFF, overflow=1.
5. Length error.
   - Stimulus: 16 elem_done pulses without vec_last, each element pp=0x0001.
   - Response: acc_out=0x00010, len_err=1, HOLD entered the cycle after the 16th elem_done.
6. Reset and restart.
   - Stimulus: assert reset_n=0 mid-ACCUM with acc=0x00123. Separately, mid-ACCUM, assert start in the same cycle as pp=0x0044.
   - Response: on reset all outputs are 0 and state is IDLE immediately. On restart the acc is 0 next cycle and 0x0044 is excluded.
